// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and flag indices for the sequential ALU
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int FLG_ZERO = 0;
    localparam int FLG_OVF  = 1;
    localparam int FLG_DZ   = 2;

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative W-step shift-add multiplier / restoring divider on one 2W accumulator
// Outputs present the accumulator value after the current step, so the final step can be registered directly.
module seq_muldiv #(
    parameter int W  = 3,
    parameter int CW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           sel,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [CW-1:0]  count,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);
    logic [2*W-1:0] acc_q, acc_d, acc_step;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W:0]     mul_sum, div_part, div_diff;

    // mul: acc = {partial product, multiplier}; div: acc = {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b} : '0);
        div_part = acc_q[2*W-1:W-1];
        div_diff = div_part - {1'b0, b};
        if (sel) begin
            if (div_part >= {1'b0, b})
                acc_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            else
                acc_step = {div_part[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[W-1:1]};
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load) begin
            acc_d = {{W{1'b0}}, a};
            cnt_d = CW'(W - 1);
        end else if (step) begin
            acc_d = acc_step;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign count     = cnt_q;
    assign product   = acc_step;
    assign quotient  = acc_step[W-1:0];
    assign remainder = acc_step[2*W-1:W];

endmodule

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - handshaked W-bit ALU: capture regs, FSM, single-cycle ops, result/flags mux
// Flag generation is present only when ALU_FLAGS_EN is defined; otherwise flags are tied to zero.
module alu_seq_param #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2:0]     opcode,
    input  logic [W-1:0]   port_a,
    input  logic [W-1:0]   port_b,
    output logic [2*W-1:0] result,
    output logic           busy,
    output logic           done,
    output logic [2:0]     flags
);
    import alu_seq_pkg::*;

    localparam int CW = $clog2(W);

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] result_q, result_d;
    logic [2*W-1:0] a_ext, b_ext, single_res, iter_res;
    logic           iter_op, eng_load, eng_step, wr_single, wr_iter;
    logic [CW-1:0]  eng_count;
    logic [2*W-1:0] eng_product;
    logic [W-1:0]   eng_quot, eng_rem;

    assign a_ext   = {{W{1'b0}}, port_a};
    assign b_ext   = {{W{1'b0}}, port_b};
    assign iter_op = (opcode == OP_MUL) || (opcode == OP_DIV);

    always_comb begin
        single_res = '0;
        case (opcode)
            OP_ADD:  single_res = a_ext + b_ext;
            OP_SUB:  single_res = a_ext - b_ext;
            OP_AND:  single_res = {{W{1'b0}}, port_a & port_b};
            OP_OR:   single_res = {{W{1'b0}}, port_a | port_b};
            OP_XOR:  single_res = {{W{1'b0}}, port_a ^ port_b};
            OP_PASS: single_res = a_ext;
            default: single_res = '0;
        endcase
    end

    seq_muldiv #(.W(W), .CW(CW)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .load      (eng_load),
        .step      (eng_step),
        .sel       (op_q == OP_DIV),
        .a         (port_a),
        .b         (b_q),
        .count     (eng_count),
        .product   (eng_product),
        .quotient  (eng_quot),
        .remainder (eng_rem)
    );

    assign iter_res = (op_q == OP_DIV) ? {eng_rem, eng_quot} : eng_product;

    // start is only looked at in IDLE, so a held start cannot re-trigger mid-operation
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        b_d       = b_q;
        eng_load  = 1'b0;
        eng_step  = 1'b0;
        wr_single = 1'b0;
        wr_iter   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = opcode;
                    b_d  = port_b;
                    if (iter_op) begin
                        eng_load = 1'b1;
                        state_d  = ST_EXEC;
                    end else begin
                        wr_single = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                eng_step = 1'b1;
                if (eng_count == '0) begin
                    wr_iter = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        result_d = wr_single ? single_res : (wr_iter ? iter_res : result_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

`ifdef ALU_FLAGS_EN
    logic [2:0] flags_q, flags_d, single_flags, iter_flags;

    always_comb begin
        single_flags           = '0;
        single_flags[FLG_ZERO] = (single_res == '0);
        single_flags[FLG_OVF]  = ((opcode == OP_ADD) && single_res[W]) ||
                                 ((opcode == OP_SUB) && (port_a < port_b));
        iter_flags             = '0;
        iter_flags[FLG_ZERO]   = (iter_res == '0);
        iter_flags[FLG_OVF]    = (op_q == OP_MUL) && (|eng_product[2*W-1:W]);
        iter_flags[FLG_DZ]     = (op_q == OP_DIV) && (b_q == '0);
        flags_d = wr_single ? single_flags : (wr_iter ? iter_flags : flags_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flags_q <= '0;
        else      flags_q <= flags_d;
    end

    assign flags = flags_q;
`else
    assign flags = 3'b000;
`endif

endmodule
